fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Parametrised successor to the core's fixed-width PC/PC_LUT front end: one block owns the program counter, a writable branch-target LUT, run control and done detection. It replaces the hard "done when PC==500" compare with halt-opcode detection plus a parametrised end address. It adds start/stall control and cycle and instruction counters. It sits between the instruction ROM (drives its address, receives its combinational mach_code) and the control/ALU (which supply branch requests).

Parameters:
D, 10, program counter width
IW, 9, machine-code width
LUT_DEPTH, 16, branch-target LUT entries
LW, 4, LUT index width (clog2 of LUT_DEPTH)
END_PC, 500, PC value that ends the run
HALT_CODE, 9'h1FF, machine code that halts the run
CW, 16, counter width

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a run from start_pc (honoured in IDLE and DONE only)
start_pc  in  D  initial PC loaded on start
stall  in  1  hold PC for this cycle
mach_code  in  IW  instruction at prog_ctr (combinational from ROM)
branch_en  in  1  take branch this cycle
branch_mode  in  1  0 = absolute (PC <= lut[idx]); 1 = relative (PC <= PC + lut[idx], two's complement)
lut_idx  in  LW  LUT entry used by the branch
lut_we  in  1  LUT write enable
lut_waddr  in  LW  LUT write index
lut_wdata  in  D  LUT write data
prog_ctr  out  D  current PC, registered
running  out  1  state == RUN
done  out  1  state == DONE, sticky
cycle_cnt  out  CW  RUN cycles this run
instr_cnt  out  CW  retired instructions this run

Behaviour:
- Reset (reset==0, asynchronous, any state):
  - state = IDLE; prog_ctr = 0; done = 0; running = 0; both counters = 0.
  - All LUT entries = 0.
  - Outputs go to these values immediately, not at the next edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1 -> RUN: prog_ctr <= start_pc; counters <= 0.
  - DONE, start=1 -> RUN: same restart, and done clears.
  - start is ignored while in RUN.
- RUN, per edge:
  - cycle_cnt increments on every RUN edge, including stall and end cycles.
  - The remaining actions take the first matching priority:
    1. prog_ctr==END_PC -> DONE; PC held; instruction not counted.
    2. stall -> PC held; instr_cnt held; branch_en and halt ignored.
    3. mach_code==HALT_CODE -> DONE; PC held; instr_cnt+1.
    4. branch_en -> PC <= target; instr_cnt+1.
    5. Otherwise -> PC <= PC+1, mod 2^D; instr_cnt+1.
- Relative branch arithmetic: D-bit add, wraps mod 2^D, no overflow flag.
- Both counters saturate at all ones (no wrap).
- LUT:
  - Synchronous write when lut_we=1, in any state.
  - Read is combinational from stored contents.
  - Write and branch to the same index in the same cycle: the branch uses the old value.
- No latency beyond one cycle: a new PC is visible the cycle after the decision.
- DONE:
  - PC and counters frozen.
  - done stays 1 until start or reset.

Test Plan:
1. Sequential run, END_PC=5, start_pc=0, no stall/branch -> prog_ctr 0,1,2,3,4,5. done rises on the edge after prog_ctr==5; final prog_ctr=5, instr_cnt=5, cycle_cnt=6.
2. Absolute branch: write lut[3]=200; at prog_ctr=4 assert branch_en, mode 0, idx 3 -> next prog_ctr=200, instr_cnt+1.
3. Relative branch:
   - lut[2]=10'h3FE; branch at prog_ctr=7 -> 5.
   - lut[1]=5; branch at prog_ctr=1022 -> 3 (wrap).
   - Same-cycle write lut[2]=9 with a branch on idx 2 -> still 5; the next branch on idx 2 uses 9.
4. Stall and halt:
   - stall for 3 cycles at prog_ctr=8 -> PC stays 8, instr_cnt unchanged, cycle_cnt +3.
   - mach_code=9'h1FF at prog_ctr=9 -> done=1, prog_ctr stays 9, instr_cnt counts the halt.
   - A branch_en asserted during the stall is ignored.
5. Asynchronous reset mid-run at prog_ctr=37: drop reset between edges -> outputs 0 immediately, LUT cleared. After release, start with start_pc=12 -> prog_ctr=12.
6. Restart and saturation:
   - start while in DONE -> done=0, counters=0, prog_ctr=start_pc.
   - start while in RUN -> no effect.
   - With CW=4, a 20-cycle run -> cycle_cnt holds at 15.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Front end of the core. It owns the program counter, a writable branch-target
// LUT, run control (IDLE / RUN / DONE) and the run counters. It drives the
// instruction ROM address and receives that ROM's combinational machine code.
// The control/ALU side supplies the branch requests.
//
// A run ends when the PC reaches END_PC or when a HALT_CODE instruction
// retires.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-low reset (clears PC, FSM, counters, LUT)
//   start        begin a run from start_pc (honoured in IDLE and DONE)
//   start_pc     initial PC loaded on start
//   stall        hold the PC for this cycle
//   mach_code    instruction at prog_ctr, combinational from the ROM
//   branch_en    take a branch this cycle
//   branch_mode  0 = absolute (lut[idx]), 1 = relative (PC + lut[idx])
//   lut_idx      LUT entry used by a branch
//   lut_we       LUT write enable
//   lut_waddr    LUT write index
//   lut_wdata    LUT write data
//   prog_ctr     current PC (registered)
//   running      FSM is in RUN
//   done         FSM is in DONE (sticky until start or reset)
//   cycle_cnt    RUN cycles in this run (saturating)
//   instr_cnt    retired instructions in this run (saturating)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int              D         = 10,
    parameter int              IW        = 9,
    parameter int              LUT_DEPTH = 16,
    parameter int              LW        = 4,
    parameter int              END_PC    = 500,
    parameter logic [IW-1:0]   HALT_CODE = 9'h1FF,
    parameter int              CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  start_pc,
    input  logic          stall,
    input  logic [IW-1:0] mach_code,
    input  logic          branch_en,
    input  logic          branch_mode,
    input  logic [LW-1:0] lut_idx,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [D-1:0] END_ADDR = D'(END_PC);

    state_t        state, state_nxt;
    logic [D-1:0]  pc_nxt;
    logic [CW-1:0] cyc_nxt;
    logic [CW-1:0] ins_nxt;
    logic [D-1:0]  lut [LUT_DEPTH];
    logic [D-1:0]  lut_entry;
    logic [D-1:0]  br_target;

    // Counters stick at all ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // The relative target is a plain D-bit add, so a large entry acts as a
    // negative offset and the result wraps modulo 2^D.
    function automatic logic [D-1:0] target_of(input logic          rel,
                                               input logic [D-1:0]  pc,
                                               input logic [D-1:0]  entry);
        return rel ? pc + entry : entry;
    endfunction

    // The read is combinational from stored contents. A branch in the same
    // cycle as a write to its index therefore sees the old entry.
    assign lut_entry = lut[lut_idx];
    assign br_target = target_of(branch_mode, prog_ctr, lut_entry);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prog_ctr  <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            state     <= state_nxt;
            prog_ctr  <= pc_nxt;
            cycle_cnt <= cyc_nxt;
            instr_cnt <= ins_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
        cyc_nxt   = cycle_cnt;
        ins_nxt   = instr_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = start_pc;
                    cyc_nxt   = '0;
                    ins_nxt   = '0;
                end
            end
            RUN: begin
                // Every RUN edge counts, including stalls and the final one.
                cyc_nxt = sat_inc(cycle_cnt);
                if (prog_ctr == END_ADDR) begin
                    // The instruction at the end address does not retire.
                    state_nxt = DONE;
                end else if (!stall) begin
                    // A stall holds everything else, so halt and branch
                    // requests are dropped for that cycle.
                    ins_nxt = sat_inc(instr_cnt);
                    if (mach_code == HALT_CODE) begin
                        state_nxt = DONE;
                    end else if (branch_en) begin
                        pc_nxt = br_target;
                    end else begin
                        pc_nxt = prog_ctr + D'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule
